// File: rtl/aca_lock_pkg.sv
// Shared constants and types for the key-locked almost-correct adder.
//   ACA_WIDTH       : operand width
//   ACA_WINDOW      : number of lower-order positions used to speculate a carry
//   ACA_KEY_W       : key width (one key bit per propagate and generate net)
//   ACA_KEY_CORRECT : unlocking key, fixed at synthesis
//   aca_result_t    : registered result, MSB is the speculative carry-out
package aca_lock_pkg;

  localparam int unsigned ACA_WIDTH  = 16;
  localparam int unsigned ACA_WINDOW = 4;
  localparam int unsigned ACA_KEY_W  = 2 * ACA_WIDTH;

  localparam logic [ACA_KEY_W-1:0] ACA_KEY_CORRECT = 32'h184B8236;

  typedef logic [ACA_WIDTH:0] aca_result_t;

endpackage : aca_lock_pkg

// File: rtl/aca_window_carry.sv
// Speculative carry from a fixed window of (generate, propagate) pairs.
// The window's carry-in is tied to 0, so the result is the OR over every
// window position j of g[j] AND all propagates above j inside the window.
//   g_win   : generate nets, index 0 is the lowest position of the window
//   p_win   : propagate nets, same ordering as g_win
//   carry_c : combinational speculative carry into the position above the window
module aca_window_carry
  import aca_lock_pkg::*;
#(
  parameter int unsigned WINDOW = ACA_WINDOW
) (
  input  logic [WINDOW-1:0] g_win,
  input  logic [WINDOW-1:0] p_win,
  output logic              carry_c
);

  // Short ripple across the window starting from a zero carry-in; this is the
  // same sum-of-products expression written as a chain of AND-OR stages.
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int unsigned k = 0; k < WINDOW; k++) begin
      acc = g_win[k] | (p_win[k] & acc);
    end
    carry_c = acc;
  end

endmodule : aca_window_carry

// File: rtl/almost_correct_adder16_aor_enc32.sv
// Logic-locked approximate adder with a registered result.
// Every propagate and generate net passes through a key gate; with the correct
// key the gates are transparent and the adder computes the almost-correct sum,
// otherwise the flipped nets feed the same carry-speculation formula.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset, clears result_o
//   add1_i    : operand A
//   add2_i    : operand B
//   keyinput  : key, sampled every cycle
//   result_o  : registered approximate sum, MSB is the speculative carry-out
module almost_correct_adder16_aor_enc32
  import aca_lock_pkg::*;
#(
  parameter int unsigned            WIDTH       = ACA_WIDTH,
  parameter int unsigned            WINDOW      = ACA_WINDOW,
  parameter logic [2*WIDTH-1:0]     KEY_CORRECT = ACA_KEY_CORRECT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     add1_i,
  input  logic [WIDTH-1:0]     add2_i,
  input  logic [2*WIDTH-1:0]   keyinput,
  output logic [WIDTH:0]       result_o
);

  localparam int unsigned EXT_W = WIDTH + WINDOW;

  logic [WIDTH-1:0] p_raw;
  logic [WIDTH-1:0] g_raw;
  logic [WIDTH-1:0] p_key;
  logic [WIDTH-1:0] g_key;
  logic [EXT_W-1:0] p_ext;
  logic [EXT_W-1:0] g_ext;
  logic [WIDTH:0]   carry;
  logic [WIDTH:0]   sum_c;

  // Half-adder nets per bit position.
  assign p_raw = add1_i ^ add2_i;
  assign g_raw = add1_i & add2_i;

  // Key gates: XOR where the correct key bit is 0, XNOR where it is 1, so the
  // correct key leaves every net unchanged.
  for (genvar i = 0; i < WIDTH; i++) begin : g_key_gate
    if (KEY_CORRECT[i]) begin : g_p_xnor
      assign p_key[i] = ~(p_raw[i] ^ keyinput[i]);
    end else begin : g_p_xor
      assign p_key[i] = p_raw[i] ^ keyinput[i];
    end

    if (KEY_CORRECT[WIDTH+i]) begin : g_g_xnor
      assign g_key[i] = ~(g_raw[i] ^ keyinput[WIDTH+i]);
    end else begin : g_g_xor
      assign g_key[i] = g_raw[i] ^ keyinput[WIDTH+i];
    end
  end

  // Zero-pad below bit 0 so low-order carries, whose windows would reach
  // below the LSB, see inert (g=0) positions and use the same window slice.
  assign p_ext = {p_key, {WINDOW{1'b0}}};
  assign g_ext = {g_key, {WINDOW{1'b0}}};

  assign carry[0] = 1'b0;

  // Carry into bit i uses bits i-WINDOW..i-1, i.e. extended indices i..i+WINDOW-1.
  for (genvar i = 1; i <= WIDTH; i++) begin : g_carry
    aca_window_carry #(
      .WINDOW (WINDOW)
    ) u_window_carry (
      .g_win   (g_ext[i +: WINDOW]),
      .p_win   (p_ext[i +: WINDOW]),
      .carry_c (carry[i])
    );
  end

  // Sum bits plus the speculative carry-out as the MSB.
  assign sum_c = {carry[WIDTH], p_key ^ carry[WIDTH-1:0]};

  // Output register; reset discards any in-flight sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_o <= '0;
    end else begin
      result_o <= sum_c;
    end
  end

endmodule : almost_correct_adder16_aor_enc32

// File: tb/tb_almost_correct_adder16_aor_enc32.sv
// Self-checking bench for the locked almost-correct adder.
// A reference model evaluates the carry-speculation formula directly from the
// windowed generate/propagate definition; every cycle the registered output is
// compared to the model's value for the previous cycle's inputs. Directed
// vectors also carry hand-computed literals, and correct-key vectors whose
// propagate runs are short enough are compared to the exact integer sum.
module tb_almost_correct_adder16_aor_enc32;

  localparam int          W   = 16;
  localparam int          WIN = 4;
  localparam logic [31:0] KC  = 32'h184B8236;

  logic          clk;
  logic          rst;
  logic [15:0]   add1_i;
  logic [15:0]   add2_i;
  logic [31:0]   keyinput;
  logic [16:0]   result_o;

  int errors;
  int checks;

  // Expectations for the result that appears after the next rising edge.
  logic          pend_vld;
  logic [16:0]   pend_model;
  logic          pend_lit_en;
  logic [16:0]   pend_lit;
  string         pend_name;
  logic          pend_exact_en;
  logic [16:0]   pend_exact;

  almost_correct_adder16_aor_enc32 dut (
    .clk      (clk),
    .rst      (rst),
    .add1_i   (add1_i),
    .add2_i   (add2_i),
    .keyinput (keyinput),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: c_i = OR over j in [max(0,i-WIN), i-1] of g'_j & p'_{j+1..i-1}.
  function automatic logic [16:0] aca_model(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input logic [31:0] key);
    logic [15:0] p;
    logic [15:0] g;
    logic [16:0] res;
    logic        c;
    logic        term;
    int          lo;
    p   = (a ^ b) ^ (key[15:0] ^ KC[15:0]);
    g   = (a & b) ^ (key[31:16] ^ KC[31:16]);
    res = '0;
    for (int i = 0; i <= W; i++) begin
      c  = 1'b0;
      lo = (i - WIN < 0) ? 0 : i - WIN;
      for (int j = lo; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c = c | term;
      end
      if (i < W) res[i] = p[i] ^ c;
      else       res[i] = c;
    end
    return res;
  endfunction

  // Longest run of consecutive propagate bits in the raw operands.
  function automatic int max_prop_run(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p;
    int run;
    int best;
    p    = a ^ b;
    run  = 0;
    best = 0;
    for (int i = 0; i < W; i++) begin
      run  = p[i] ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    return best;
  endfunction

  task automatic compare(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  // One cycle: check the result of the previous cycle's inputs, then drive new ones.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [31:0] key,
                      input logic r, input logic lit_en, input logic [16:0] lit,
                      input string name);
    @(negedge clk);
    if (pend_vld) begin
      compare("model", result_o, pend_model);
      if (pend_lit_en)   compare(pend_name, result_o, pend_lit);
      if (pend_exact_en) compare("exact_sum", result_o, pend_exact);
    end
    add1_i   = a;
    add2_i   = b;
    keyinput = key;
    rst      = r;
    pend_vld      = 1'b1;
    pend_model    = r ? 17'h00000 : aca_model(a, b, key);
    pend_lit_en   = lit_en;
    pend_lit      = lit;
    pend_name     = name;
    // A generate followed by at most WIN-1 propagates stays inside every window.
    pend_exact_en = !r && (key == KC) && (max_prop_run(a, b) <= WIN - 1);
    pend_exact    = {1'b0, a} + {1'b0, b};
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    pend_vld      = 1'b0;
    pend_model    = '0;
    pend_lit_en   = 1'b0;
    pend_lit      = '0;
    pend_name     = "";
    pend_exact_en = 1'b0;
    pend_exact    = '0;
    rst      = 1'b1;
    add1_i   = '0;
    add2_i   = '0;
    keyinput = KC;

    // Reset and release.
    step(16'h0000, 16'h0000, KC, 1'b1, 1'b1, 17'h00000, "reset");
    step(16'h1234, 16'hFFFF, KC, 1'b1, 1'b1, 17'h00000, "reset_any_inputs");
    step(16'h0000, 16'h0000, KC, 1'b0, 1'b1, 17'h00000, "release_zero");

    // Exact cases, correct key.
    step(16'h5555, 16'hAAAA, KC, 1'b0, 1'b1, 17'h0FFFF, "exact_5555_aaaa");
    step(16'hABCD, 16'h0000, KC, 1'b0, 1'b1, 17'h0ABCD, "exact_abcd_0");
    step(16'h0000, 16'h0001, KC, 1'b0, 1'b1, 17'h00001, "exact_0_1");
    step(16'h1100, 16'h1111, KC, 1'b0, 1'b1, 17'h02211, "exact_1100_1111");
    step(16'h8000, 16'h8000, KC, 1'b0, 1'b1, 17'h10000, "exact_carry_out");

    // Approximation boundary: carry chains longer than the window are lost.
    step(16'h00FF, 16'h0001, KC, 1'b0, 1'b1, 17'h000E0, "approx_00ff_1");
    step(16'hFFFF, 16'h0001, KC, 1'b0, 1'b1, 17'h0FFE0, "approx_ffff_1");
    step(16'h001F, 16'h0001, KC, 1'b0, 1'b1, 17'h00000, "approx_run4");
    step(16'h000F, 16'h0001, KC, 1'b0, 1'b1, 17'h00010, "exact_run3");

    // Wrong keys on zero operands.
    step(16'h0000, 16'h0000, 32'h184B8237, 1'b0, 1'b1, 17'h00001, "wrongkey_bit0");
    step(16'h0000, 16'h0000, 32'h184A8236, 1'b0, 1'b1, 17'h00002, "wrongkey_bit16");
    step(16'h0000, 16'h0000, KC ^ 32'h8000_0000, 1'b0, 1'b1, 17'h10000, "wrongkey_bit31");

    // Back-to-back operands, mid-stream reset, then recovery.
    step(16'h29AF, 16'h7A1B, KC, 1'b0, 1'b0, 17'h00000, "b2b_0");
    step(16'h4482, 16'h3BCD, KC, 1'b0, 1'b0, 17'h00000, "b2b_1");
    step(16'hFFFF, 16'hFFFF, KC, 1'b1, 1'b1, 17'h00000, "midstream_reset");
    step(16'h1234, 16'h4321, KC, 1'b0, 1'b1, 17'h05555, "after_reset");
    step(16'h1234, 16'h4321, 32'h0000_0000, 1'b0, 1'b0, 17'h00000, "key_change");

    // Random operands, half with the correct key and half with random keys.
    for (int n = 0; n < 10000; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [31:0] rk;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rk = ($urandom_range(0, 1) == 1) ? KC : $urandom;
      step(ra, rb, rk, 1'b0, 1'b0, 17'h00000, "random");
    end

    // Flush the final pending expectation.
    step(16'h0000, 16'h0000, KC, 1'b0, 1'b0, 17'h00000, "flush");
    @(negedge clk);
    compare("model", result_o, pend_model);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_almost_correct_adder16_aor_enc32
